// File: rtl/jt51_wrqueue.sv
// jt51_wrqueue: host-side FIFO of register/data pairs for the jt51 write bus.
// Each pair is replayed as an address strobe then a data strobe, paced by cen_p1 and busy_in.
module jt51_wrqueue #(
  parameter int AW    = 4,
  parameter int GUARD = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen_p1,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [7:0]    host_addr,
  input  logic [7:0]    host_data,
  input  logic          flush,
  output logic [AW:0]   level,
  output logic          empty,
  input  logic          busy_in,
  output logic          cs_n,
  output logic          wr_n,
  output logic          a0,
  output logic [7:0]    dout
);
  localparam int DEPTH = 1 << AW;
  localparam int CW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [CW-1:0] HLAST = (GUARD > 0) ? CW'(GUARD - 1) : '0;

  typedef enum logic [1:0] {IDLE, WR_ADDR, WR_DATA, HOLDOFF} state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_hcnt, w_hcnt_next;

  logic [7:0]    r_mem_addr [DEPTH];
  logic [7:0]    r_mem_data [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_level;
  logic [7:0]    r_head_addr, r_head_data;
  logic          r_head_valid;

  logic          r_cs_n, r_wr_n, r_a0;
  logic [7:0]    r_dout;
  logic          w_cs_n_next, w_a0_next;
  logic [7:0]    w_dout_next;

  logic          w_push, w_pop, w_inprog;

  assign host_ready = !rst && !flush && (r_level < (AW+1)'(DEPTH));
  assign level      = r_level;
  assign empty      = (r_level == '0);
  assign w_push     = host_valid && host_ready;
  assign w_pop      = (r_state == WR_DATA) && cen_p1;
  assign w_inprog   = (r_state == WR_ADDR) || (r_state == WR_DATA);

  assign cs_n = r_cs_n;
  assign wr_n = r_wr_n;
  assign a0   = r_a0;
  assign dout = r_dout;

  // Storage with a registered head read; the head is one cycle behind the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wptr] <= host_addr;
      r_mem_data[r_wptr] <= host_data;
    end
    r_head_addr <= r_mem_addr[r_rptr];
    r_head_data <= r_mem_data[r_rptr];
  end

  // Flush keeps only the pair currently on the bus, which still pops normally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_head_valid <= 1'b0;
    end else begin
      r_rptr       <= r_rptr + AW'(w_pop);
      r_head_valid <= !flush && (r_level != '0);
      if (flush) begin
        r_wptr  <= r_rptr + AW'(w_inprog);
        r_level <= (AW+1)'(w_inprog) - (AW+1)'(w_pop);
      end else begin
        r_wptr  <= r_wptr + AW'(w_push);
        r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hcnt  <= '0;
      r_cs_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_a0    <= 1'b0;
      r_dout  <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_hcnt  <= w_hcnt_next;
      r_cs_n  <= w_cs_n_next;
      r_wr_n  <= w_cs_n_next;
      r_a0    <= w_a0_next;
      r_dout  <= w_dout_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hcnt_next  = r_hcnt;
    case (r_state)
      IDLE:    if (r_head_valid && !empty && !busy_in) w_state_next = WR_ADDR;
      WR_ADDR: if (cen_p1) w_state_next = WR_DATA;
      WR_DATA: if (cen_p1) w_state_next = HOLDOFF;
      HOLDOFF: begin
        if (GUARD == 0) begin
          w_state_next = IDLE;
        end else if (cen_p1) begin
          if (r_hcnt == HLAST) begin
            w_state_next = IDLE;
            w_hcnt_next  = '0;
          end else begin
            w_hcnt_next = r_hcnt + CW'(1);
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Bus values follow the next state so strobes line up with the state they belong to.
  always_comb begin
    w_cs_n_next = 1'b1;
    w_a0_next   = r_a0;
    w_dout_next = r_dout;
    case (w_state_next)
      WR_ADDR: begin
        w_cs_n_next = 1'b0;
        w_a0_next   = 1'b0;
        w_dout_next = r_head_addr;
      end
      WR_DATA: begin
        w_cs_n_next = 1'b0;
        w_a0_next   = 1'b1;
        w_dout_next = r_head_data;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/jt51_wrqueue.md
JT51_WRQUEUE -- requirements
Module: jt51_wrqueue

Interface
REQ-001 The module SHALL have parameter AW, default 4, setting FIFO depth DEPTH=2^AW register/data pairs.
REQ-002 The module SHALL have parameter GUARD, default 2, giving the number of cen_p1 pulses to wait after a data write before busy_in is sampled.
REQ-003 The module SHALL have port clk, input, 1 bit: the single main clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port cen_p1, input, 1 bit: the chip's half-speed clock enable, at which the chip samples writes.
REQ-006 The module SHALL have port host_valid, input, 1 bit: the host offers a pair.
REQ-007 The module SHALL have port host_ready, output, 1 bit: the queue accepts a pair this cycle.
REQ-008 The module SHALL have port host_addr, input, 8 bits: chip register address.
REQ-009 The module SHALL have port host_data, input, 8 bits: register value.
REQ-010 The module SHALL have port flush, input, 1 bit: discard all queued, not-yet-started pairs.
REQ-011 The module SHALL have port level, output, AW+1 bits: number of queued pairs.
REQ-012 The module SHALL have port empty, output, 1 bit: level==0.
REQ-013 The module SHALL have port busy_in, input, 1 bit: chip busy flag (chip dout[7]).
REQ-014 The module SHALL have ports cs_n, wr_n and a0, each output, 1 bit: chip bus strobes.
REQ-015 The module SHALL have port dout, output, 8 bits: chip data bus (chip din).

Function
REQ-016 host_ready SHALL equal !rst && !flush && level<DEPTH; a push occurs on any clk edge where host_valid && host_ready.
REQ-017 Pairs SHALL be issued in strict push order; the FIFO read/write pointers SHALL wrap modulo DEPTH.
REQ-018 The FSM SHALL have states IDLE, WR_ADDR, WR_DATA and HOLDOFF.
REQ-019 IDLE -> WR_ADDR SHALL occur when !empty && !busy_in; otherwise the FSM stays in IDLE.
REQ-020 WR_ADDR SHALL drive cs_n=0, wr_n=0, a0=0, dout=head addr, and hold them through the first cycle with cen_p1=1 (inclusive); the next state is WR_DATA.
REQ-021 WR_DATA SHALL drive cs_n=0, wr_n=0, a0=1, dout=head data, and hold them through the first cycle with cen_p1=1.
REQ-022 On the exit edge of WR_DATA, the head entry SHALL be popped and the next state is HOLDOFF.
REQ-023 HOLDOFF SHALL drive cs_n=1 and wr_n=1, and count GUARD cen_p1 pulses, then return to IDLE; busy_in SHALL be ignored outside IDLE.
REQ-024 Outside WR_ADDR and WR_DATA, cs_n and wr_n SHALL be 1, while a0 and dout hold their last values.
REQ-025 All bus outputs SHALL be registered and never glitch.
REQ-026 Latency: a push into an empty queue with busy_in=0 SHALL give cs_n=0 on the second clk edge after the push edge.
REQ-027 On a simultaneous push and pop, level SHALL be unchanged and both operations take effect.
REQ-028 When full, host_ready=0; after a pop at edge n, host_ready=1 in the cycle following edge n.
REQ-029 flush=1 SHALL, at that edge, set level to the count of the in-progress pair (1 if state is WR_ADDR or WR_DATA, else 0), and the in-progress pair SHALL complete normally.
REQ-030 Any push attempted in a flush cycle SHALL be dropped.
REQ-031 If busy_in stays high indefinitely, the FSM SHALL remain in IDLE with the queue intact.

Reset
REQ-032 While rst=1 at a clk edge: state=IDLE, level=0, empty=1, pointers=0, HOLDOFF counter=0, cs_n=1, wr_n=1, a0=0, dout=8'h00, host_ready=0.
REQ-033 Reset asserted mid-transaction SHALL abort it on that edge (cs_n=1, wr_n=1 the following cycle) and discard the queue.

Verification
REQ-034 Single pair: push {0x20,0xC7}, busy_in=0, cen_p1 every 2nd cycle -> chip sees a0=0/din=0x20 write then a0=1/din=0xC7 write; level 1 -> 0; empty=1.
REQ-035 Fill: push 17 pairs with busy_in=1 (AW=4) -> host_ready=0 after 16 pushes, level=16; release busy -> 16 pairs issued in order.
REQ-036 Busy gating: drive busy_in=1 for 40 cycles after each data write -> next WR_ADDR begins only after busy_in=0 and the GUARD pulses have elapsed.
REQ-037 Flush: queue 5 pairs, assert flush during the first WR_DATA -> first pair completes, level=0 after the pop, no further strobes.
REQ-038 Reset mid-write: rst=1 during WR_ADDR -> cs_n=1 and level=0 the next cycle; a new push is accepted after rst falls.
